tx_sched_rr: RTL and testbench
==============================

# tx_sched_rr

Round-robin transmit scheduler that turns per-queue doorbells into transmit requests for one port. It keeps a FIFO of active queue indices, issues one request per FIFO pop with a tag taken from a small outstanding-operation table, and retires or re-queues each queue from the dequeue status returned by the transmit engine. One instance drives one input port of the transmit request mux and consumes that port's demuxed status.

## Interface
- QUEUE_INDEX_WIDTH, 4: queue index width; FIFO depth = 2**QUEUE_INDEX_WIDTH.
- REQ_TAG_WIDTH, 8: request tag width; must be >= $clog2(OP_TABLE_SIZE), otherwise elaboration error.
- OP_TABLE_SIZE, 16: maximum outstanding requests (power of two).
- DEST_WIDTH, 8: request dest width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_doorbell_queue  in  QUEUE_INDEX_WIDTH  queue with new work.
- s_axis_doorbell_dest  in  DEST_WIDTH  dest recorded for that queue.
- s_axis_doorbell_valid  in  1  doorbell valid.
- s_axis_doorbell_ready  out  1  doorbell accepted when valid && ready.
- m_axis_req_queue  out  QUEUE_INDEX_WIDTH  request queue.
- m_axis_req_tag  out  REQ_TAG_WIDTH  op slot index, zero-extended.
- m_axis_req_dest  out  DEST_WIDTH  request dest.
- m_axis_req_valid  out  1  request valid.
- m_axis_req_ready  in  1  request accepted.
- s_axis_status_dequeue_empty  in  1  queue was empty.
- s_axis_status_dequeue_error  in  1  dequeue error.
- s_axis_status_dequeue_tag  in  REQ_TAG_WIDTH  tag of completed request.
- s_axis_status_dequeue_valid  in  1  status valid (no backpressure).
- enable  in  1  issue enable; does not gate doorbells or status.
- active_count  out  QUEUE_INDEX_WIDTH+1  queues currently scheduled.

## Operation
- Per-queue state: scheduled bit (queue in FIFO or has an outstanding op), pending bit, dest register.
- Doorbell on q:
  - not scheduled: push q to FIFO tail, set scheduled, store dest.
  - scheduled: store dest, set pending.
- Issue: when enable, FIFO non-empty, a free op slot exists and the output register is empty or being accepted:
  - pop head, allocate the lowest free slot, record the queue in the slot, load the output register.
- Dequeue status with tag t whose slot is busy: free slot t; let q = slot queue; clear pending.
  - empty=0, error=0: re-push q at tail (round robin).
  - empty=1 or error=1 (error dominates empty): re-push q if pending was set, else clear scheduled.
- Status for a free slot or tag >= OP_TABLE_SIZE: ignored.
- FIFO never overflows: each queue is present at most once. Single push port; status push has priority.
- s_axis_doorbell_ready = !rst && !(s_axis_status_dequeue_valid). A doorbell stalled by status retries on the next cycle.
- Doorbell for q in the same cycle as status for q is impossible by construction (ready low).
- active_count = popcount of scheduled bits, registered.

## Timing
- Reset clears the FIFO, scheduled/pending bits and slot table.
- Reset values: m_axis_req_valid=0; queue, tag and dest = 0; active_count=0; s_axis_doorbell_ready=0 while rst is high.
- Output register: valid, queue, tag and dest stay stable while valid && !ready.
- Doorbell accepted in cycle 0 into an idle block: FIFO push at edge 0, pop in cycle 1, m_axis_req_valid high in cycle 2.
- Status in cycle k re-pushes: reissue of that queue has valid high at k+2 at the earliest.
- Throughput: one request per cycle while FIFO and slots are available and ready=1.
- Slot table full: issue stalls; the first status frees a slot, and that slot can be allocated in the next cycle.
- Reset mid-operation: all outstanding ops are dropped; status arriving afterwards is ignored.

## Test plan
- Doorbell q=3, dest=0x11, ready=1: req valid in cycle 2 with queue=3, tag=0, dest=0x11. Status empty=1 tag=0: active_count returns to 0.
- Doorbells q=1,2,5: requests in order 1,2,5. Status non-empty for each: reissued in order 1,2,5 again. Tags are lowest-free.
- OP_TABLE_SIZE=4 with 6 active queues: only 4 requests issued. Status for tag 2: next request carries tag 2.
- Doorbell q=7 while its op is outstanding, then status empty=1: q=7 is reissued exactly once and pending is cleared. Without the extra doorbell, q=7 is retired.
- Hold m_axis_req_ready=0 for 5 cycles: outputs stable; no pop or slot allocation beyond the held request.
- Status valid concurrent with doorbell valid: doorbell_ready=0 that cycle, doorbell accepted next cycle. Assert rst with 3 ops outstanding: valid=0 and active_count=0 next cycle; later stale status is ignored.

Source files
------------

// File: rtl/tx_sched_rr_if.sv
// Doorbell, transmit request and dequeue status channels of the round-robin
// transmit scheduler; slave is the scheduler's view, master the peer's.
interface tx_sched_rr_if #(
  parameter int QUEUE_INDEX_WIDTH = 4,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int DEST_WIDTH        = 8
);
  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_doorbell_queue;
  logic [DEST_WIDTH-1:0]        s_axis_doorbell_dest;
  logic                         s_axis_doorbell_valid;
  logic                         s_axis_doorbell_ready;

  logic [QUEUE_INDEX_WIDTH-1:0] m_axis_req_queue;
  logic [REQ_TAG_WIDTH-1:0]     m_axis_req_tag;
  logic [DEST_WIDTH-1:0]        m_axis_req_dest;
  logic                         m_axis_req_valid;
  logic                         m_axis_req_ready;

  logic                         s_axis_status_dequeue_empty;
  logic                         s_axis_status_dequeue_error;
  logic [REQ_TAG_WIDTH-1:0]     s_axis_status_dequeue_tag;
  logic                         s_axis_status_dequeue_valid;

  modport slave (
    input  s_axis_doorbell_queue, s_axis_doorbell_dest, s_axis_doorbell_valid,
    output s_axis_doorbell_ready,
    output m_axis_req_queue, m_axis_req_tag, m_axis_req_dest, m_axis_req_valid,
    input  m_axis_req_ready,
    input  s_axis_status_dequeue_empty, s_axis_status_dequeue_error,
    input  s_axis_status_dequeue_tag, s_axis_status_dequeue_valid
  );

  modport master (
    output s_axis_doorbell_queue, s_axis_doorbell_dest, s_axis_doorbell_valid,
    input  s_axis_doorbell_ready,
    input  m_axis_req_queue, m_axis_req_tag, m_axis_req_dest, m_axis_req_valid,
    output m_axis_req_ready,
    output s_axis_status_dequeue_empty, s_axis_status_dequeue_error,
    output s_axis_status_dequeue_tag, s_axis_status_dequeue_valid
  );
endinterface

// File: rtl/tx_sched_rr.sv
// Round-robin transmit scheduler: FIFO of active queues, one request per pop,
// tags from an outstanding-op table, retire/re-queue from dequeue status.
module tx_sched_rr #(
  parameter int QUEUE_INDEX_WIDTH = 4,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int OP_TABLE_SIZE     = 16,
  parameter int DEST_WIDTH        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  tx_sched_rr_if.slave               sched_if,
  input  logic                       enable,
  output logic [QUEUE_INDEX_WIDTH:0] active_count
);
  localparam int QW  = QUEUE_INDEX_WIDTH;
  localparam int NQ  = 2**QW;
  localparam int OPS = OP_TABLE_SIZE;
  localparam int SW  = (OPS > 1) ? $clog2(OPS) : 1;

  if (REQ_TAG_WIDTH < $clog2(OP_TABLE_SIZE)) begin : g_tag_width_check
    $error("REQ_TAG_WIDTH cannot hold an op table index");
  end

  logic [NQ-1:0]                 sched_q, sched_d, pend_q, pend_d;
  logic [NQ-1:0][DEST_WIDTH-1:0] dest_q, dest_d;
  logic [NQ-1:0][QW-1:0]         fifo_q, fifo_d;
  logic [QW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW:0]                   cnt_q, cnt_d;
  logic [OPS-1:0]                busy_q, busy_d;
  logic [OPS-1:0][QW-1:0]        slot_queue_q, slot_queue_d;
  logic                          req_valid_q, req_valid_d;
  logic [QW-1:0]                 req_queue_q, req_queue_d;
  logic [SW-1:0]                 req_slot_q, req_slot_d;
  logic [DEST_WIDTH-1:0]         req_dest_q, req_dest_d;
  logic [QW:0]                   active_q, active_d;

  logic          db_fire, st_hit, push, free_any, out_free, issue;
  logic [SW-1:0] st_slot, free_slot;
  logic [QW-1:0] st_queue, push_queue, pop_queue;

  // Status and doorbell share the single FIFO push port; status wins.
  assign sched_if.s_axis_doorbell_ready = !rst && !sched_if.s_axis_status_dequeue_valid;

  assign db_fire  = sched_if.s_axis_doorbell_valid && sched_if.s_axis_doorbell_ready;
  assign st_slot  = sched_if.s_axis_status_dequeue_tag[SW-1:0];
  assign st_hit   = sched_if.s_axis_status_dequeue_valid
                 && ((sched_if.s_axis_status_dequeue_tag >> SW) == '0)
                 && busy_q[st_slot];
  assign st_queue = slot_queue_q[st_slot];
  assign out_free = !req_valid_q || sched_if.m_axis_req_ready;
  assign pop_queue = fifo_q[rd_ptr_q];

  always_comb begin
    free_any  = 1'b0;
    free_slot = '0;
    for (int i = OPS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any  = 1'b1;
        free_slot = SW'(i);
      end
    end
  end

  assign issue = enable && (cnt_q != '0) && free_any && out_free;

  always_comb begin
    sched_d      = sched_q;
    pend_d       = pend_q;
    dest_d       = dest_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    busy_d       = busy_q;
    slot_queue_d = slot_queue_q;
    req_valid_d  = req_valid_q;
    req_queue_d  = req_queue_q;
    req_slot_d   = req_slot_q;
    req_dest_d   = req_dest_q;
    push         = 1'b0;
    push_queue   = '0;

    if (st_hit) begin
      busy_d[st_slot] = 1'b0;
      pend_d[st_queue] = 1'b0;
      push_queue = st_queue;
      // Non-empty dequeue keeps the queue in rotation; otherwise only a
      // doorbell seen while the op was outstanding keeps it alive.
      if ((!sched_if.s_axis_status_dequeue_empty && !sched_if.s_axis_status_dequeue_error)
          || pend_q[st_queue])
        push = 1'b1;
      else
        sched_d[st_queue] = 1'b0;
    end else if (db_fire) begin
      dest_d[sched_if.s_axis_doorbell_queue] = sched_if.s_axis_doorbell_dest;
      if (!sched_q[sched_if.s_axis_doorbell_queue]) begin
        sched_d[sched_if.s_axis_doorbell_queue] = 1'b1;
        push       = 1'b1;
        push_queue = sched_if.s_axis_doorbell_queue;
      end else begin
        pend_d[sched_if.s_axis_doorbell_queue] = 1'b1;
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q] = push_queue;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      busy_d[free_slot]       = 1'b1;
      slot_queue_d[free_slot] = pop_queue;
      req_valid_d = 1'b1;
      req_queue_d = pop_queue;
      req_slot_d  = free_slot;
      req_dest_d  = dest_q[pop_queue];
    end else if (out_free) begin
      req_valid_d = 1'b0;
    end
  end

  assign cnt_d = cnt_q + (QW+1)'(push) - (QW+1)'(issue);

  always_comb begin
    active_d = '0;
    for (int i = 0; i < NQ; i++) active_d = active_d + (QW+1)'(sched_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sched_q      <= '0;
      pend_q       <= '0;
      dest_q       <= '0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      busy_q       <= '0;
      slot_queue_q <= '0;
      req_valid_q  <= 1'b0;
      req_queue_q  <= '0;
      req_slot_q   <= '0;
      req_dest_q   <= '0;
      active_q     <= '0;
    end else begin
      sched_q      <= sched_d;
      pend_q       <= pend_d;
      dest_q       <= dest_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      slot_queue_q <= slot_queue_d;
      req_valid_q  <= req_valid_d;
      req_queue_q  <= req_queue_d;
      req_slot_q   <= req_slot_d;
      req_dest_q   <= req_dest_d;
      active_q     <= active_d;
    end
  end

  assign sched_if.m_axis_req_valid = req_valid_q;
  assign sched_if.m_axis_req_queue = req_queue_q;
  assign sched_if.m_axis_req_tag   = REQ_TAG_WIDTH'(req_slot_q);
  assign sched_if.m_axis_req_dest  = req_dest_q;
  assign active_count              = active_q;
endmodule

// File: tb/tb_tx_sched_rr.sv
// Bench for tx_sched_rr: directed scenarios plus randomized traffic checked
// cycle by cycle against a queue-based reference model.
module tb_tx_sched_rr;
  localparam int QW  = 4;
  localparam int TW  = 8;
  localparam int OPS = 4;
  localparam int DW  = 8;
  localparam int NQ  = 2**QW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [QW:0] active_count;

  tx_sched_rr_if #(.QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(TW), .DEST_WIDTH(DW)) bus ();

  tx_sched_rr #(
    .QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(TW), .OP_TABLE_SIZE(OPS), .DEST_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .sched_if(bus), .enable(enable), .active_count(active_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: scheduler state as plain queues/arrays.
  int  m_fifo[$];
  bit  m_sched[NQ];
  bit  m_pend[NQ];
  int  m_dest[NQ];
  bit  m_busy[OPS];
  int  m_slotq[OPS];
  bit  m_vld;
  int  m_q, m_tag, m_dst;
  int  eng[$];          // tags the transmit engine holds and may answer
  bit  db_last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_active();
    int n = 0;
    for (int i = 0; i < NQ; i++) n += int'(m_sched[i]);
    return n;
  endfunction

  task automatic model_step();
    int  fs, hq, hd, t, q;
    bit  out_free, iss;
    if (rst) begin
      m_fifo.delete();
      eng.delete();
      for (int i = 0; i < NQ; i++) begin m_sched[i] = 0; m_pend[i] = 0; m_dest[i] = 0; end
      for (int i = 0; i < OPS; i++) begin m_busy[i] = 0; m_slotq[i] = 0; end
      m_vld = 0; m_q = 0; m_tag = 0; m_dst = 0;
      return;
    end
    out_free = !m_vld || bus.m_axis_req_ready;
    if (m_vld && bus.m_axis_req_ready) eng.push_back(m_tag);
    fs = -1;
    for (int i = OPS - 1; i >= 0; i--) if (!m_busy[i]) fs = i;
    iss = enable && (m_fifo.size() > 0) && (fs >= 0) && out_free;
    hq = iss ? m_fifo[0] : 0;
    hd = iss ? m_dest[hq] : 0;
    if (bus.s_axis_status_dequeue_valid) begin
      t = int'(bus.s_axis_status_dequeue_tag);
      if (t < OPS && m_busy[t]) begin
        q = m_slotq[t];
        m_busy[t] = 0;
        if ((!bus.s_axis_status_dequeue_empty && !bus.s_axis_status_dequeue_error) || m_pend[q])
          m_fifo.push_back(q);
        else
          m_sched[q] = 0;
        m_pend[q] = 0;
      end
    end else if (bus.s_axis_doorbell_valid) begin
      q = int'(bus.s_axis_doorbell_queue);
      m_dest[q] = int'(bus.s_axis_doorbell_dest);
      if (!m_sched[q]) begin m_sched[q] = 1; m_fifo.push_back(q); end
      else m_pend[q] = 1;
    end
    if (iss) begin
      void'(m_fifo.pop_front());
      m_busy[fs] = 1; m_slotq[fs] = hq;
      m_vld = 1; m_q = hq; m_tag = fs; m_dst = hd;
    end else if (out_free) begin
      m_vld = 0;
    end
  endtask

  // One clock: check ready on the current inputs, step the model, advance to
  // the next falling edge and compare registered outputs with the model.
  task automatic cycle();
    #1;
    chk("db_ready", bus.s_axis_doorbell_ready, !rst && !bus.s_axis_status_dequeue_valid);
    db_last_acc = bus.s_axis_doorbell_valid && !rst && !bus.s_axis_status_dequeue_valid;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("req_valid", bus.m_axis_req_valid, m_vld);
    if (m_vld) begin
      chk("req_queue", bus.m_axis_req_queue, m_q);
      chk("req_tag", bus.m_axis_req_tag, m_tag);
      chk("req_dest", bus.m_axis_req_dest, m_dst);
    end
    chk("active_count", active_count, m_active());
  endtask

  task automatic idle();
    bus.s_axis_doorbell_valid       = 1'b0;
    bus.s_axis_doorbell_queue       = '0;
    bus.s_axis_doorbell_dest        = '0;
    bus.s_axis_status_dequeue_valid = 1'b0;
    bus.s_axis_status_dequeue_empty = 1'b0;
    bus.s_axis_status_dequeue_error = 1'b0;
    bus.s_axis_status_dequeue_tag   = '0;
  endtask

  task automatic db(input int q, input int d);
    bus.s_axis_doorbell_valid = 1'b1;
    bus.s_axis_doorbell_queue = QW'(q);
    bus.s_axis_doorbell_dest  = DW'(d);
  endtask

  task automatic status(input int t, input bit empty, input bit error);
    bus.s_axis_status_dequeue_valid = 1'b1;
    bus.s_axis_status_dequeue_tag   = TW'(t);
    bus.s_axis_status_dequeue_empty = empty;
    bus.s_axis_status_dequeue_error = error;
  endtask

  task automatic rand_inputs();
    int idx, t;
    rst    = ($urandom_range(0, 299) == 0);
    enable = ($urandom_range(0, 9) != 0);
    bus.m_axis_req_ready = ($urandom_range(0, 3) != 0);
    bus.s_axis_status_dequeue_valid = 1'b0;
    bus.s_axis_status_dequeue_empty = ($urandom_range(0, 2) == 0);
    bus.s_axis_status_dequeue_error = ($urandom_range(0, 7) == 0);
    if (eng.size() > 0 && $urandom_range(0, 2) == 0) begin
      idx = int'($urandom_range(0, eng.size() - 1));
      bus.s_axis_status_dequeue_tag   = TW'(eng[idx]);
      bus.s_axis_status_dequeue_valid = 1'b1;
      eng.delete(idx);
    end else if ($urandom_range(0, 15) == 0) begin
      // stray status: free slot or out-of-range tag, must be ignored
      t = int'($urandom_range(0, 2*OPS - 1));
      if (t >= OPS || !m_busy[t]) begin
        bus.s_axis_status_dequeue_tag   = TW'(t);
        bus.s_axis_status_dequeue_valid = 1'b1;
      end
    end
    if (!bus.s_axis_doorbell_valid || db_last_acc) begin
      bus.s_axis_doorbell_valid = ($urandom_range(0, 2) == 0);
      bus.s_axis_doorbell_queue = QW'($urandom_range(0, NQ - 1));
      bus.s_axis_doorbell_dest  = DW'($urandom);
    end
  endtask

  initial begin
    idle();
    bus.m_axis_req_ready = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_valid", bus.m_axis_req_valid, 0);
    chk("rst_queue", bus.m_axis_req_queue, 0);
    chk("rst_tag", bus.m_axis_req_tag, 0);
    chk("rst_dest", bus.m_axis_req_dest, 0);
    chk("rst_active", active_count, 0);

    // Single doorbell into an idle block: request visible two cycles later.
    rst = 1'b0; enable = 1'b1;
    db(3, 'h11);
    cycle();
    idle();
    chk("lat_c1_valid", bus.m_axis_req_valid, 0);
    chk("lat_c1_active", active_count, 1);
    cycle();
    chk("lat_c2_valid", bus.m_axis_req_valid, 1);
    chk("lat_c2_queue", bus.m_axis_req_queue, 3);
    chk("lat_c2_tag", bus.m_axis_req_tag, 0);
    chk("lat_c2_dest", bus.m_axis_req_dest, 'h11);
    cycle();
    status(0, 1'b1, 1'b0);
    eng.delete();
    cycle();
    idle();
    cycle();
    chk("retire_active", active_count, 0);
    chk("retire_valid", bus.m_axis_req_valid, 0);

    // Randomized traffic against the model.
    db_last_acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      cycle();
    end

    // Order 1,2,5 with lowest-free tags, then reset with three ops outstanding.
    idle();
    rst = 1'b1; enable = 1'b1; bus.m_axis_req_ready = 1'b1;
    cycle();
    rst = 1'b0;
    db(1, 'h21); cycle();
    db(2, 'h22); cycle();
    chk("ord_q1", bus.m_axis_req_queue, 1);
    chk("ord_t1", bus.m_axis_req_tag, 0);
    chk("ord_d1", bus.m_axis_req_dest, 'h21);
    db(5, 'h25); cycle();
    chk("ord_q2", bus.m_axis_req_queue, 2);
    chk("ord_t2", bus.m_axis_req_tag, 1);
    idle(); cycle();
    chk("ord_q5", bus.m_axis_req_queue, 5);
    chk("ord_t5", bus.m_axis_req_tag, 2);
    chk("ord_d5", bus.m_axis_req_dest, 'h25);
    chk("ord_active", active_count, 3);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("midrst_valid", bus.m_axis_req_valid, 0);
    chk("midrst_active", active_count, 0);
    status(1, 1'b0, 1'b0); cycle();
    idle(); cycle(); cycle();
    chk("stale_valid", bus.m_axis_req_valid, 0);
    chk("stale_active", active_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
